// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencing blocks: sequencer state encoding,
// the MAC flag bundle, floating-point format widths and the FP zero word.
package mac_pkg;

  // Sequencer states; WAIT is only reachable when the MAC output is registered.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } mac_state_e;

  // Exception flags reported by mac_unit for one operation.
  typedef struct packed {
    logic exc;
    logic ovf;
    logic unf;
  } mac_flags_t;

  // bfloat16 layout
  localparam int BF16_WIDTH      = 16;
  localparam int BF16_EXP_WIDTH  = 8;
  localparam int BF16_MANT_WIDTH = 7;

  // IEEE single-precision layout
  localparam int FP32_WIDTH      = 32;
  localparam int FP32_EXP_WIDTH  = 8;
  localparam int FP32_MANT_WIDTH = 23;

  // Positive zero, wide enough for every supported format.
  localparam logic [FP32_WIDTH-1:0] FP_ZERO = '0;

endpackage

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: drives an external mac_unit to compute
//   acc = init_acc + sum(op_a[i] * op_b[i]) over vec_len operand pairs,
// feeding the running accumulator back to the MAC addend and presenting one
// result with sticky exception flags on a valid/ready result port.
//
// Build option MAC_OUT_REG_EN: registers the operands into the MAC and adds a
// WAIT state that samples the MAC result one cycle later, breaking the path
// from op_* through the MAC into the accumulator (1 pair every 2 cycles).
// Without it, the MAC sits combinationally between op_* and acc (1 pair/cycle).
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int BIT_WIDTH  = BF16_WIDTH,
  parameter int EXP_WIDTH  = BF16_EXP_WIDTH,
  parameter int MANT_WIDTH = BF16_MANT_WIDTH,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  // job control
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] vec_len,
  input  logic [BIT_WIDTH-1:0] init_acc,
  output logic                 busy,
  // operand stream
  input  logic                 op_valid,
  output logic                 op_ready,
  input  logic [BIT_WIDTH-1:0] op_a,
  input  logic [BIT_WIDTH-1:0] op_b,
  // mac_unit interface
  output logic [BIT_WIDTH-1:0] mac_a,
  output logic [BIT_WIDTH-1:0] mac_b,
  output logic [BIT_WIDTH-1:0] mac_c,
  input  logic [BIT_WIDTH-1:0] mac_out,
  input  logic                 mac_exc,
  input  logic                 mac_ovf,
  input  logic                 mac_unf,
  // result port
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [BIT_WIDTH-1:0] res_data,
  output logic                 res_exc,
  output logic                 res_ovf,
  output logic                 res_unf
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [BIT_WIDTH-1:0] ACC_ZERO = BIT_WIDTH'(FP_ZERO);

  // Only the two formats mac_unit is built for are accepted.
  if (!((BIT_WIDTH == BF16_WIDTH && EXP_WIDTH == BF16_EXP_WIDTH &&
         MANT_WIDTH == BF16_MANT_WIDTH) ||
        (BIT_WIDTH == FP32_WIDTH && EXP_WIDTH == FP32_EXP_WIDTH &&
         MANT_WIDTH == FP32_MANT_WIDTH))) begin : g_format_check
    $error("mac_dot_sequencer: unsupported FP format %0d/%0d/%0d",
           BIT_WIDTH, EXP_WIDTH, MANT_WIDTH);
  end

  mac_state_e           state_q;
  logic [BIT_WIDTH-1:0] acc_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] count_q;
  logic [LEN_WIDTH-1:0] count_d;
  mac_flags_t           flags_q;
  mac_flags_t           flags_d;
  mac_flags_t           mac_flags;
  logic                 busy_q;
  logic                 op_ready_q;
  logic                 res_valid_q;
  logic                 beat;

`ifdef MAC_OUT_REG_EN
  logic [BIT_WIDTH-1:0] mac_a_q;
  logic [BIT_WIDTH-1:0] mac_b_q;
`endif

  // An operand pair is consumed only while the operand port is open.
  assign beat      = op_valid & op_ready_q;
  assign mac_flags = '{exc: mac_exc, ovf: mac_ovf, unf: mac_unf};

  // Next values of the beat counter and the sticky flag accumulation.
  always_comb begin
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    count_d = count_q + LEN_ONE;
    flags_d = flags_q | mac_flags;
  end

`ifdef MAC_OUT_REG_EN
  // Operands reach the MAC from the registers loaded on the accepting beat.
  assign mac_a = mac_a_q;
  assign mac_b = mac_b_q;
`else
  // Operands pass straight through to the MAC while the operand port is open.
  always_comb begin
    mac_a = ACC_ZERO;
    mac_b = ACC_ZERO;
    if (op_ready_q) begin
      mac_a = op_a;
      mac_b = op_b;
    end
  end
`endif

  // Sequencer FSM with its counter, accumulator, sticky flags and registered
  // handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= ACC_ZERO;
      len_q       <= '0;
      count_q     <= '0;
      flags_q     <= '0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
`ifdef MAC_OUT_REG_EN
      mac_a_q     <= ACC_ZERO;
      mac_b_q     <= ACC_ZERO;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_q   <= vec_len;
            acc_q   <= init_acc;
            count_q <= '0;
            flags_q <= '0;
            busy_q  <= 1'b1;
            if (vec_len == '0) begin
              state_q     <= ST_DONE;
              res_valid_q <= 1'b1;
            end else begin
              state_q    <= ST_RUN;
              op_ready_q <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (beat) begin
            count_q <= count_d;
`ifdef MAC_OUT_REG_EN
            mac_a_q    <= op_a;
            mac_b_q    <= op_b;
            op_ready_q <= 1'b0;
            state_q    <= ST_WAIT;
`else
            acc_q   <= mac_out;
            flags_q <= flags_d;
            if (count_q == len_q - LEN_ONE) begin
              op_ready_q  <= 1'b0;
              res_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
`endif
          end
        end

        ST_WAIT: begin
`ifdef MAC_OUT_REG_EN
          // count_q already includes the beat now leaving the MAC.
          acc_q   <= mac_out;
          flags_q <= flags_d;
          if (count_q == len_q) begin
            res_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            op_ready_q <= 1'b1;
            state_q    <= ST_RUN;
          end
`else
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
`endif
        end

        ST_DONE: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign op_ready  = op_ready_q;
  assign mac_c     = acc_q;
  assign res_valid = res_valid_q;
  assign res_data  = acc_q;
  assign res_exc   = flags_q.exc;
  assign res_ovf   = flags_q.ovf;
  assign res_unf   = flags_q.unf;

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Bench for mac_dot_sequencer (bfloat16). A behavioural bfloat16 MAC built on
// real arithmetic stands in for mac_unit; expected results fold the same MAC
// rule over each job's operand list. Honours MAC_OUT_REG_EN like the design.
module tb_mac_dot_sequencer;

`ifdef MAC_OUT_REG_EN
  localparam int          RES_LAT   = 2;
  localparam logic [7:0]  READY_PAT = 8'b0000_1010;
`else
  localparam int          RES_LAT   = 1;
  localparam logic [7:0]  READY_PAT = 8'b0000_0011;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  vec_len;
  logic [15:0] init_acc;
  logic        busy;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] mac_a;
  logic [15:0] mac_b;
  logic [15:0] mac_c;
  logic [15:0] mac_out;
  logic        mac_exc;
  logic        mac_ovf;
  logic        mac_unf;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_data;
  logic        res_exc;
  logic        res_ovf;
  logic        res_unf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pa[$];
  logic [15:0] pb[$];

  mac_dot_sequencer #(
    .BIT_WIDTH (16),
    .EXP_WIDTH (8),
    .MANT_WIDTH(7),
    .LEN_WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .vec_len  (vec_len),
    .init_acc (init_acc),
    .busy     (busy),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .mac_a    (mac_a),
    .mac_b    (mac_b),
    .mac_c    (mac_c),
    .mac_out  (mac_out),
    .mac_exc  (mac_exc),
    .mac_ovf  (mac_ovf),
    .mac_unf  (mac_unf),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_exc  (res_exc),
    .res_ovf  (res_ovf),
    .res_unf  (res_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bfloat16 -> real (denormals flushed to zero).
  function automatic real bf2real(input logic [15:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[14:7] == 8'h00) begin
      d = {x[15], 63'b0};
    end else if (x[14:7] == 8'hFF) begin
      d = {x[15], 11'h7FF, x[6:0], 45'b0};
    end else begin
      e = 11'(x[14:7]) + 11'd896;
      d = {x[15], e, x[6:0], 45'b0};
    end
    return $bitstoreal(d);
  endfunction

  // real -> {exc, ovf, unf, bfloat16}, truncating the mantissa.
  function automatic logic [18:0] real2bf(input real r);
    logic [63:0] d;
    logic [15:0] o;
    logic        exc;
    logic        ovf;
    logic        unf;
    int          be;
    d   = $realtobits(r);
    exc = 1'b0;
    ovf = 1'b0;
    unf = 1'b0;
    if (d[62:52] == 11'h7FF) begin
      if (d[51:0] != 52'd0) begin
        o   = 16'h7FC0;
        exc = 1'b1;
      end else begin
        o = {d[63], 8'hFF, 7'h00};
      end
    end else if (d[62:52] == 11'h000) begin
      o = {d[63], 15'h0000};
    end else begin
      be = int'(d[62:52]) - 896;
      if (be >= 255) begin
        o   = {d[63], 8'hFF, 7'h00};
        ovf = 1'b1;
      end else if (be <= 0) begin
        o   = {d[63], 15'h0000};
        unf = 1'b1;
      end else begin
        o = {d[63], be[7:0], d[51:45]};
      end
    end
    return {exc, ovf, unf, o};
  endfunction

  // One MAC operation: a*b + c.
  function automatic logic [18:0] mac_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [15:0] c);
    return real2bf(bf2real(a) * bf2real(b) + bf2real(c));
  endfunction

  // Finite operand with a moderate exponent so random sums stay in range.
  function automatic logic [15:0] rand_bf();
    logic [7:0] e;
    e = 8'($urandom_range(134, 120));
    return {1'($urandom), e, 7'($urandom)};
  endfunction

  // Stand-in for mac_unit.
  always_comb begin
    {mac_exc, mac_ovf, mac_unf, mac_out} = mac_fn(mac_a, mac_b, mac_c);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic fill_random(input int len);
    pa = {};
    pb = {};
    for (int i = 0; i < len; i++) begin
      pa.push_back(rand_bf());
      pb.push_back(rand_bf());
    end
  endtask

  // Runs one job over pa/pb from a negedge and returns at a negedge with the
  // DUT back in IDLE. gap_pct: chance of withholding op_valid in a ready cycle;
  // hold: cycles res_ready stays low; noise: keep start high while busy.
  task automatic run_job(input int len, input logic [15:0] init, input int gap_pct,
                         input int hold, input bit noise, input bit chk_pat,
                         input string tag, output logic [15:0] got_data,
                         output logic [2:0] got_flags);
    logic [15:0] exp_acc;
    logic [2:0]  exp_fl;
    logic [18:0] r;
    logic [7:0]  hist;
    int          idx;
    int          last_it;
    int          done_it;
    int          nhist;

    exp_acc = init;
    exp_fl  = 3'b000;
    for (int i = 0; i < len; i++) begin
      r       = mac_fn(pa[i], pb[i], exp_acc);
      exp_acc = r[15:0];
      exp_fl  = exp_fl | r[18:16];
    end

    start    = 1'b1;
    vec_len  = 8'(len);
    init_acc = init;
    @(negedge clk);
    start    = noise;
    vec_len  = 8'($urandom);
    init_acc = 16'($urandom);

    idx = 0; last_it = -1; done_it = -1; hist = 8'h00; nhist = 0;
    for (int it = 0; it < 700; it++) begin
      if (res_valid) begin
        done_it = it;
        break;
      end
      hist = {hist[6:0], op_ready};
      nhist++;
      if (op_ready && idx < len && int'($urandom_range(99)) >= gap_pct) begin
        op_valid = 1'b1;
        op_a     = pa[idx];
        op_b     = pb[idx];
        idx++;
        last_it  = it;
      end else begin
        op_valid = 1'b0;
        op_a     = 16'($urandom);
        op_b     = 16'($urandom);
      end
      @(negedge clk);
    end
    op_valid = 1'b0;
    start    = 1'b0;

    check({tag, " res_valid"}, res_valid, 1);
    check({tag, " busy"}, busy, 1);
    check({tag, " op_ready_closed"}, op_ready, 0);
    check({tag, " beats"}, idx, len);
    check({tag, " res_data"}, res_data, exp_acc);
    check({tag, " flags"}, {res_exc, res_ovf, res_unf}, exp_fl);
    if (len == 0) check({tag, " done_latency"}, done_it, 0);
    else          check({tag, " res_latency"}, done_it - last_it, RES_LAT);
    if (chk_pat) begin
      check({tag, " ready_cycles"}, nhist, len * RES_LAT);
      check({tag, " ready_pattern"}, hist, READY_PAT);
    end
    got_data  = res_data;
    got_flags = {res_exc, res_ovf, res_unf};

    res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " held_valid"}, res_valid, 1);
      check({tag, " held_data"}, {res_data, res_exc, res_ovf, res_unf}, {exp_acc, exp_fl});
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    check({tag, " busy_after_accept"}, busy, 0);
    check({tag, " valid_after_accept"}, res_valid, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no summary expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] d;
    logic [2:0]  f;
    logic [15:0] new_init;

    rst = 1'b1; start = 1'b0; vec_len = '0; init_acc = '0;
    op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset op_ready", op_ready, 0);
    check("reset res_valid", res_valid, 0);
    check("reset res_data", res_data, 0);
    check("reset flags", {res_exc, res_ovf, res_unf}, 0);
    check("reset mac_c", mac_c, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", busy, 0);

    // 1*2 + 3*1 from zero -> 5.0
    pa = {16'h3F80, 16'h4040};
    pb = {16'h4000, 16'h3F80};
    run_job(2, 16'h0000, 0, 0, 1'b0, 1'b1, "basic", d, f);
    check("basic const_data", d, 16'h40A0);
    check("basic const_flags", f, 0);

    // zero-length job reports the initial accumulator
    pa = {}; pb = {};
    run_job(0, 16'h3F80, 0, 0, 1'b0, 1'b0, "len0", d, f);
    check("len0 const_data", d, 16'h3F80);

    // valid gaps, back-pressured result, start noise while busy
    fill_random(3);
    run_job(3, rand_bf(), 40, 5, 1'b1, 1'b0, "gaps", d, f);

    // overflow on the second beat stays sticky to the result
    fill_random(4);
    pa[1] = 16'h7F00;
    pb[1] = 16'h7F00;
    run_job(4, rand_bf(), 20, 1, 1'b0, 1'b0, "ovf", d, f);
    check("ovf const_flag", f[1], 1);

    // reset after one of four beats
    fill_random(4);
    start = 1'b1; vec_len = 8'd4; init_acc = rand_bf();
    @(negedge clk);
    start = 1'b0;
    check("midrst ready", op_ready, 1);
    op_valid = 1'b1; op_a = pa[0]; op_b = pb[0];
    @(negedge clk);
    op_valid = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("midrst busy", busy, 0);
    check("midrst res_valid", res_valid, 0);
    check("midrst op_ready", op_ready, 0);
    check("midrst acc", res_data, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst idle_valid", res_valid, 0);
    new_init = rand_bf();
    fill_random(3);
    run_job(3, new_init, 10, 0, 1'b0, 1'b0, "after_rst", d, f);

    for (int j = 0; j < 6; j++) begin
      int len;
      len = int'($urandom_range(12, 1));
      fill_random(len);
      run_job(len, rand_bf(), 30, int'($urandom_range(3)), 1'($urandom), 1'b0, "rand", d, f);
    end

    // longest programmable vector
    fill_random(255);
    run_job(255, rand_bf(), 0, 0, 1'b0, 1'b0, "max_len", d, f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
